// File: rtl/common.sv
// common: shared types for the pipeline stages.
//   word_t / u64        64-bit datapath word
//   decoded_op_t        decoded instruction op, including the load/store ops
//   execute_data_t      bundle from execute into the MEM stage
//   memory_data_t       bundle from the MEM stage into writeback
//   dbus_req_t/_resp_t  data bus handshake (valid/addr_ok/data_ok)
//   mem_state_t         MEM stage handshake FSM states
package common;

    typedef logic [63:0] u64;
    typedef u64          word_t;
    typedef logic [63:0] addr_t;
    typedef logic [4:0]  creg_addr_t;
    typedef logic [11:0] csr_addr_t;
    typedef logic [7:0]  strobe_t;

    typedef enum logic [4:0] {
        UNKNOWN, ALU, ADDI, LUI, BRANCH, JAL, CSR,
        LB, LH, LW, LD, LBU, LHU, LWU,
        SB, SH, SW, SD
    } decoded_op_t;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
        ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
    } alufunc_t;

    typedef struct packed {
        decoded_op_t op;
        alufunc_t    alufunc;
        logic        regwrite;
    } control_t;

    typedef struct packed {
        u64         pc;
        control_t   ctl;
        creg_addr_t dst;
        addr_t      mem_addr;
        word_t      result;      // ALU result, or store data for S* ops
        csr_addr_t  csr_addr;
        word_t      csr_result;
    } execute_data_t;

    typedef struct packed {
        u64         pc;
        control_t   ctl;
        creg_addr_t dst;
        word_t      result;      // value to write back
        csr_addr_t  csr_addr;
        word_t      csr_result;
    } memory_data_t;

    typedef enum logic [1:0] {
        MSIZE1, MSIZE2, MSIZE4, MSIZE8
    } msize_t;

    typedef struct packed {
        logic    valid;
        addr_t   addr;
        msize_t  size;
        strobe_t strobe;
        word_t   data;
    } dbus_req_t;

    typedef struct packed {
        logic  addr_ok;
        logic  data_ok;
        word_t data;
    } dbus_resp_t;

    typedef enum logic [1:0] {
        IDLE, WAIT, DONE
    } mem_state_t;

    function automatic logic isMemOp(input decoded_op_t op);
        return op inside {LB, LH, LW, LD, LBU, LHU, LWU, SB, SH, SW, SD};
    endfunction

endpackage

// File: rtl/mem_align.sv
// mem_align: combinational byte-lane formatting for the MEM stage.
//   op        decoded op (non-memory ops give size MSIZE1, no strobe, no misalign)
//   addrLow   mem_addr[2:0], byte offset within the 64-bit bus word
//   storeIn   raw store data (low bytes significant)
//   loadIn    raw bus read word
//   size      access size for the bus request
//   strobe    byte-enable for stores, zero for loads
//   storeData storeIn moved to its byte lane
//   loadData  loadIn moved down from its byte lane, truncated and extended
//   misalign  offset is not a multiple of the access size
//   isLoad    op is a load
//   isStore   op is a store
module mem_align
    import common::*;
(
    input  decoded_op_t op,
    input  logic [2:0]  addrLow,
    input  word_t       storeIn,
    input  word_t       loadIn,
    output msize_t      size,
    output strobe_t     strobe,
    output word_t       storeData,
    output word_t       loadData,
    output logic        misalign,
    output logic        isLoad,
    output logic        isStore
);

    logic    signExt;
    strobe_t byteMask;
    word_t   shifted;
    logic [5:0] bitOffset;

    assign bitOffset = {addrLow, 3'b000};

    always_comb begin
        size    = MSIZE1;
        isLoad  = 1'b0;
        isStore = 1'b0;
        signExt = 1'b0;
        case (op)
            LB:  begin size = MSIZE1; isLoad = 1'b1; signExt = 1'b1; end
            LH:  begin size = MSIZE2; isLoad = 1'b1; signExt = 1'b1; end
            LW:  begin size = MSIZE4; isLoad = 1'b1; signExt = 1'b1; end
            LD:  begin size = MSIZE8; isLoad = 1'b1; end
            LBU: begin size = MSIZE1; isLoad = 1'b1; end
            LHU: begin size = MSIZE2; isLoad = 1'b1; end
            LWU: begin size = MSIZE4; isLoad = 1'b1; end
            SB:  begin size = MSIZE1; isStore = 1'b1; end
            SH:  begin size = MSIZE2; isStore = 1'b1; end
            SW:  begin size = MSIZE4; isStore = 1'b1; end
            SD:  begin size = MSIZE8; isStore = 1'b1; end
            default: ;
        endcase
    end

    always_comb begin
        byteMask = 8'h01;
        misalign = 1'b0;
        case (size)
            MSIZE1: begin byteMask = 8'h01; misalign = 1'b0;          end
            MSIZE2: begin byteMask = 8'h03; misalign = addrLow[0];    end
            MSIZE4: begin byteMask = 8'h0F; misalign = |addrLow[1:0]; end
            MSIZE8: begin byteMask = 8'hFF; misalign = |addrLow;      end
            default: ;
        endcase
    end

    assign strobe    = isStore ? strobe_t'(byteMask << addrLow) : '0;
    assign storeData = storeIn << bitOffset;
    assign shifted   = loadIn >> bitOffset;

    always_comb begin
        loadData = shifted;
        case (size)
            MSIZE1: loadData = signExt ? {{56{shifted[7]}}, shifted[7:0]}
                                       : {56'b0, shifted[7:0]};
            MSIZE2: loadData = signExt ? {{48{shifted[15]}}, shifted[15:0]}
                                       : {48'b0, shifted[15:0]};
            MSIZE4: loadData = signExt ? {{32{shifted[31]}}, shifted[31:0]}
                                       : {32'b0, shifted[31:0]};
            MSIZE8: loadData = shifted;
            default: ;
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// memory_stage: pipeline MEM stage between execute and writeback.
//   clk, reset  clock, synchronous active-high reset
//   dataE       execute bundle; held stable by upstream while stallM=1
//   validE      dataE carries a real instruction
//   dreq        data bus request (valid until addr_ok, then dropped)
//   dresp       data bus response (addr_ok, data_ok, read data)
//   dataM       writeback bundle
//   validM      dataM valid this cycle
//   stallM      hold all upstream stage registers
//   misalignM   memory op is misaligned; completes without a bus access
// Non-memory ops pass through combinationally. A memory op stalls in IDLE/WAIT
// until data_ok, then spends one cycle in DONE presenting the result.
module memory_stage
    import common::*;
(
    input  logic          clk,
    input  logic          reset,
    input  execute_data_t dataE,
    input  logic          validE,
    output dbus_req_t     dreq,
    input  dbus_resp_t    dresp,
    output memory_data_t  dataM,
    output logic          validM,
    output logic          stallM,
    output logic          misalignM
);

    mem_state_t state;
    logic       addrSeen;   // addr_ok already taken for the outstanding request
    word_t      loadQ;

    msize_t  size;
    strobe_t strobe;
    word_t   storeData;
    word_t   loadData;
    logic    misalign;
    logic    isLoad;
    logic    isStore;
    logic    memOp;
    logic    memReq;

    mem_align u_align (
        .op       (dataE.ctl.op),
        .addrLow  (dataE.mem_addr[2:0]),
        .storeIn  (dataE.result),
        .loadIn   (dresp.data),
        .size     (size),
        .strobe   (strobe),
        .storeData(storeData),
        .loadData (loadData),
        .misalign (misalign),
        .isLoad   (isLoad),
        .isStore  (isStore)
    );

    assign memOp  = validE && isMemOp(dataE.ctl.op);
    assign memReq = memOp && !misalign;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            addrSeen <= 1'b0;
            loadQ    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // data_ok without a request of ours is stale and ignored
                    if (memReq) begin
                        if (dresp.data_ok) begin
                            state <= DONE;
                            if (isLoad) loadQ <= loadData;
                        end else begin
                            state    <= WAIT;
                            addrSeen <= dresp.addr_ok;
                        end
                    end
                end
                WAIT: begin
                    if (dresp.addr_ok) addrSeen <= 1'b1;
                    if (dresp.data_ok) begin
                        state <= DONE;
                        if (isLoad) loadQ <= loadData;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    addrSeen <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    addrSeen <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        // Request fields come straight from dataE, which upstream holds while stalled.
        dreq.valid  = 1'b0;
        dreq.addr   = dataE.mem_addr;
        dreq.size   = size;
        dreq.strobe = strobe;
        dreq.data   = storeData;

        dataM.pc         = dataE.pc;
        dataM.ctl        = dataE.ctl;
        dataM.dst        = dataE.dst;
        dataM.result     = dataE.result;
        dataM.csr_addr   = dataE.csr_addr;
        dataM.csr_result = dataE.csr_result;

        validM    = 1'b0;
        stallM    = 1'b0;
        misalignM = 1'b0;

        case (state)
            IDLE: begin
                if (memOp && misalign) begin
                    misalignM          = 1'b1;
                    validM             = 1'b1;
                    dataM.ctl.regwrite = 1'b0;
                end else if (memReq) begin
                    dreq.valid = 1'b1;
                    stallM     = 1'b1;
                end else begin
                    validM = validE;
                end
            end
            WAIT: begin
                dreq.valid = !addrSeen;
                stallM     = 1'b1;
            end
            DONE: begin
                validM = 1'b1;
                if (isLoad)  dataM.result       = loadQ;
                if (isStore) dataM.ctl.regwrite = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_memory_stage.sv
module tb_memory_stage;
    import common::*;

    logic          clk = 1'b0;
    logic          reset;
    execute_data_t dataE;
    logic          validE;
    dbus_req_t     dreq;
    dbus_resp_t    dresp;
    memory_data_t  dataM;
    logic          validM;
    logic          stallM;
    logic          misalignM;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    memory_stage dut (
        .clk      (clk),
        .reset    (reset),
        .dataE    (dataE),
        .validE   (validE),
        .dreq     (dreq),
        .dresp    (dresp),
        .dataM    (dataM),
        .validM   (validM),
        .stallM   (stallM),
        .misalignM(misalignM)
    );

    // ---------------- reference model ----------------
    function automatic int opBytes(input decoded_op_t op);
        case (op)
            LB, LBU, SB: return 1;
            LH, LHU, SH: return 2;
            LW, LWU, SW: return 4;
            default:     return 8;
        endcase
    endfunction

    function automatic bit opIsLoad(input decoded_op_t op);
        return op inside {LB, LH, LW, LD, LBU, LHU, LWU};
    endfunction

    function automatic bit opSigned(input decoded_op_t op);
        return op inside {LB, LH, LW};
    endfunction

    function automatic msize_t expSize(input decoded_op_t op);
        case (opBytes(op))
            1:       return MSIZE1;
            2:       return MSIZE2;
            4:       return MSIZE4;
            default: return MSIZE8;
        endcase
    endfunction

    function automatic logic [7:0] expStrobe(input decoded_op_t op, input int off);
        int m;
        if (opIsLoad(op)) return 8'h00;
        m = ((1 << opBytes(op)) - 1) << off;
        return m[7:0];
    endfunction

    function automatic u64 expLoad(input decoded_op_t op, input u64 bus, input int off);
        int n;
        u64 sh, mask, v;
        n    = opBytes(op);
        sh   = bus >> (8 * off);
        mask = (n == 8) ? '1 : ((64'd1 << (8 * n)) - 64'd1);
        v    = sh & mask;
        if (opSigned(op) && v[8*n-1]) v = v | ~mask;
        return v;
    endfunction

    // Drives one instruction and a bus responder (addr_ok in cycle aDly,
    // data_ok aDly+dDly), returns what was observed until completion.
    task automatic run_mem(input decoded_op_t op, input u64 addr, input u64 wdata,
                           input u64 bus, input int aDly, input int dDly,
                           output execute_data_t eOut, output int stallCnt,
                           output int validMCnt, output int reqCnt, output bit reqChanged,
                           output dbus_req_t firstReq, output memory_data_t outM,
                           output bit sawMisalign, output bit timedOut);
        execute_data_t e;
        int k;
        bit done;
        e                = '0;
        e.pc             = 64'h8000_0000 + 64'($urandom_range(0, 1023)) * 4;
        e.ctl.op         = op;
        e.ctl.alufunc    = ALU_ADD;
        e.ctl.regwrite   = 1'b1;
        e.dst            = creg_addr_t'($urandom_range(1, 31));
        e.mem_addr       = addr;
        e.result         = wdata;
        e.csr_addr       = csr_addr_t'($urandom);
        e.csr_result     = {$urandom, $urandom};
        eOut             = e;
        stallCnt = 0; validMCnt = 0; reqCnt = 0; reqChanged = 0;
        firstReq = '0; outM = '0; sawMisalign = 0;
        @(posedge clk); #1;
        dataE  = e;
        validE = 1'b1;
        k = 0; done = 0;
        while (!done && k < 64) begin
            dresp.addr_ok = (k == aDly);
            dresp.data_ok = (k == aDly + dDly);
            dresp.data    = dresp.data_ok ? bus : {$urandom, $urandom};
            #4;
            if (stallM)    stallCnt++;
            if (validM)    validMCnt++;
            if (misalignM) sawMisalign = 1;
            if (dreq.valid) begin
                if (reqCnt == 0) firstReq = dreq;
                else if (dreq.addr !== firstReq.addr || dreq.size !== firstReq.size ||
                         dreq.strobe !== firstReq.strobe || dreq.data !== firstReq.data)
                    reqChanged = 1;
                reqCnt++;
            end
            if (validM && !stallM) begin
                outM = dataM;
                done = 1;
            end
            @(posedge clk); #1;
            k++;
        end
        timedOut = !done;
        validE = 1'b0;
        dataE  = '0;
        dresp  = '0;
        #4;
        if (validM) validMCnt++;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1; validE = 1'b0; dataE = '0; dresp = '0;
        repeat (2) @(posedge clk);
        #1; reset = 1'b0;
        #4;
        total++; if (dreq.valid !== 1'b0) begin bad++; $display("FAIL reset_dreq_valid got=%b want=0", dreq.valid); end
        total++; if (validM !== 1'b0) begin bad++; $display("FAIL reset_validM got=%b want=0", validM); end
        total++; if (stallM !== 1'b0) begin bad++; $display("FAIL reset_stallM got=%b want=0", stallM); end
        total++; if (misalignM !== 1'b0) begin bad++; $display("FAIL reset_misalignM got=%b want=0", misalignM); end
    endtask

    task automatic test_sd();
        execute_data_t e; int sc, vc, rc; bit ch, mis, to; dbus_req_t fr; memory_data_t m;
        run_mem(SD, 64'h8000_1000, 64'h1122_3344_5566_7788, {$urandom, $urandom}, 0, 0,
                e, sc, vc, rc, ch, fr, m, mis, to);
        total++; if (to) begin bad++; $display("FAIL sd_timeout got=timeout want=done"); end
        total++; if (fr.strobe !== 8'hFF) begin bad++; $display("FAIL sd_strobe got=%h want=ff", fr.strobe); end
        total++; if (fr.size !== MSIZE8) begin bad++; $display("FAIL sd_size got=%0d want=%0d", fr.size, MSIZE8); end
        total++; if (fr.data !== 64'h1122_3344_5566_7788) begin bad++; $display("FAIL sd_data got=%h want=1122334455667788", fr.data); end
        total++; if (fr.addr !== 64'h8000_1000) begin bad++; $display("FAIL sd_addr got=%h want=80001000", fr.addr); end
        total++; if (sc !== 1) begin bad++; $display("FAIL sd_stall_cycles got=%0d want=1", sc); end
        total++; if (vc !== 1) begin bad++; $display("FAIL sd_validM_pulses got=%0d want=1", vc); end
        total++; if (m.ctl.regwrite !== 1'b0) begin bad++; $display("FAIL sd_regwrite got=%b want=0", m.ctl.regwrite); end
    endtask

    task automatic test_lb();
        execute_data_t e; int sc, vc, rc; bit ch, mis, to; dbus_req_t fr; memory_data_t m;
        run_mem(LB, 64'h8000_1003, 0, 64'h0000_0000_8000_0000, 1, 1,
                e, sc, vc, rc, ch, fr, m, mis, to);
        total++; if (m.result !== 64'hFFFF_FFFF_FFFF_FF80) begin bad++; $display("FAIL lb_result got=%h want=ffffffffffffff80", m.result); end
        total++; if (fr.strobe !== 8'h00) begin bad++; $display("FAIL lb_strobe got=%h want=00", fr.strobe); end
        total++; if (m.ctl.regwrite !== 1'b1) begin bad++; $display("FAIL lb_regwrite got=%b want=1", m.ctl.regwrite); end
        total++; if (m.dst !== e.dst) begin bad++; $display("FAIL lb_dst got=%0d want=%0d", m.dst, e.dst); end
        run_mem(LBU, 64'h8000_1003, 0, 64'h0000_0000_8000_0000, 0, 2,
                e, sc, vc, rc, ch, fr, m, mis, to);
        total++; if (m.result !== 64'h80) begin bad++; $display("FAIL lbu_result got=%h want=80", m.result); end
        total++; if (sc !== 3) begin bad++; $display("FAIL lbu_stall_cycles got=%0d want=3", sc); end
    endtask

    task automatic test_sh();
        execute_data_t e; int sc, vc, rc; bit ch, mis, to; dbus_req_t fr; memory_data_t m;
        run_mem(SH, 64'h8000_1006, 64'hABCD, 0, 0, 1, e, sc, vc, rc, ch, fr, m, mis, to);
        total++; if (fr.strobe !== 8'hC0) begin bad++; $display("FAIL sh_strobe got=%h want=c0", fr.strobe); end
        total++; if (fr.data !== 64'hABCD_0000_0000_0000) begin bad++; $display("FAIL sh_data got=%h want=abcd000000000000", fr.data); end
        total++; if (fr.size !== MSIZE2) begin bad++; $display("FAIL sh_size got=%0d want=%0d", fr.size, MSIZE2); end
        total++; if (m.result !== 64'hABCD) begin bad++; $display("FAIL sh_result got=%h want=abcd", m.result); end
    endtask

    task automatic test_lw_delay();
        execute_data_t e; int sc, vc, rc; bit ch, mis, to; dbus_req_t fr; memory_data_t m;
        run_mem(LW, 64'h8000_1008, 0, 64'h1234_5678_FEDC_BA98, 2, 2,
                e, sc, vc, rc, ch, fr, m, mis, to);
        total++; if (sc !== 5) begin bad++; $display("FAIL lw_stall_cycles got=%0d want=5", sc); end
        total++; if (vc !== 1) begin bad++; $display("FAIL lw_validM_pulses got=%0d want=1", vc); end
        total++; if (rc !== 3) begin bad++; $display("FAIL lw_req_cycles got=%0d want=3", rc); end
        total++; if (ch !== 1'b0) begin bad++; $display("FAIL lw_req_stable got=changed want=stable"); end
        total++; if (fr.size !== MSIZE4) begin bad++; $display("FAIL lw_size got=%0d want=%0d", fr.size, MSIZE4); end
        total++; if (m.result !== 64'hFFFF_FFFF_FEDC_BA98) begin bad++; $display("FAIL lw_result got=%h want=fffffffffedcba98", m.result); end
    endtask

    task automatic test_misalign();
        execute_data_t e; int sc, vc, rc; bit ch, mis, to; dbus_req_t fr; memory_data_t m;
        run_mem(LD, 64'h8000_1004, 0, 0, 3, 0, e, sc, vc, rc, ch, fr, m, mis, to);
        total++; if (mis !== 1'b1) begin bad++; $display("FAIL mis_flag got=%b want=1", mis); end
        total++; if (rc !== 0) begin bad++; $display("FAIL mis_req_cycles got=%0d want=0", rc); end
        total++; if (sc !== 0) begin bad++; $display("FAIL mis_stall_cycles got=%0d want=0", sc); end
        total++; if (vc !== 1) begin bad++; $display("FAIL mis_validM_pulses got=%0d want=1", vc); end
        total++; if (m.ctl.regwrite !== 1'b0) begin bad++; $display("FAIL mis_regwrite got=%b want=0", m.ctl.regwrite); end
    endtask

    task automatic test_passthrough();
        execute_data_t e;
        e = '0;
        e.pc = 64'h8000_0200; e.ctl.op = ADDI; e.ctl.regwrite = 1'b1;
        e.dst = 5'd7; e.result = {$urandom, $urandom}; e.mem_addr = 64'h8000_1001;
        @(posedge clk); #1;
        dataE = e; validE = 1'b1;
        #4;
        total++; if (validM !== 1'b1 || stallM !== 1'b0) begin bad++; $display("FAIL pass_valid_stall got=%b%b want=10", validM, stallM); end
        total++; if (dataM.result !== e.result) begin bad++; $display("FAIL pass_result got=%h want=%h", dataM.result, e.result); end
        total++; if (dreq.valid !== 1'b0 || misalignM !== 1'b0) begin bad++; $display("FAIL pass_noreq got=%b%b want=00", dreq.valid, misalignM); end
        // bubble carrying stale load fields must do nothing
        @(posedge clk); #1;
        e.ctl.op = LD; e.mem_addr = 64'h8000_1000;
        dataE = e; validE = 1'b0;
        #4;
        total++; if (dreq.valid !== 1'b0 || validM !== 1'b0 || stallM !== 1'b0) begin
            bad++; $display("FAIL bubble got=%b%b%b want=000", dreq.valid, validM, stallM);
        end
        @(posedge clk); #1;
        dataE = '0;
    endtask

    task automatic test_reset_wait();
        execute_data_t e;
        e = '0;
        e.ctl.op = LW; e.ctl.regwrite = 1'b1; e.dst = 5'd3; e.mem_addr = 64'h8000_1010;
        @(posedge clk); #1;
        dataE = e; validE = 1'b1; dresp = '0;
        #4;
        total++; if (dreq.valid !== 1'b1 || stallM !== 1'b1) begin bad++; $display("FAIL rw_first got=%b%b want=11", dreq.valid, stallM); end
        @(posedge clk); #1;
        #4;
        total++; if (dreq.valid !== 1'b1 || stallM !== 1'b1) begin bad++; $display("FAIL rw_wait got=%b%b want=11", dreq.valid, stallM); end
        @(posedge clk); #1;
        reset = 1'b1; validE = 1'b0; dataE = '0;
        @(posedge clk); #1;
        reset = 1'b0;
        dresp.data_ok = 1'b1; dresp.data = {$urandom, $urandom};  // late response
        #4;
        total++; if (dreq.valid !== 1'b0 || stallM !== 1'b0 || validM !== 1'b0) begin
            bad++; $display("FAIL rw_after_reset got=%b%b%b want=000", dreq.valid, stallM, validM);
        end
        @(posedge clk); #1;
        dresp = '0;
        e = '0;
        e.ctl.op = ADDI; e.ctl.regwrite = 1'b1; e.dst = 5'd9; e.result = {$urandom, $urandom};
        dataE = e; validE = 1'b1;
        #4;
        total++; if (validM !== 1'b1 || stallM !== 1'b0 || dataM.result !== e.result) begin
            bad++; $display("FAIL rw_addi got=%b%b %h want=10 %h", validM, stallM, dataM.result, e.result);
        end
        @(posedge clk); #1;
        validE = 1'b0; dataE = '0;
    endtask

    task automatic test_random();
        decoded_op_t ops[11] = '{LB, LH, LW, LD, LBU, LHU, LWU, SB, SH, SW, SD};
        for (int i = 0; i < 40; i++) begin
            execute_data_t e; int sc, vc, rc; bit ch, mis, to; dbus_req_t fr; memory_data_t m;
            decoded_op_t op; int n, off, aD, dD; u64 addr, wd, bus, wantRes; bit wantMis, ld;
            op   = ops[$urandom_range(0, 10)];
            n    = opBytes(op);
            off  = $urandom_range(0, 7);
            if ($urandom_range(0, 3) != 0) off = off - (off % n);
            addr = 64'h8000_1000 + (64'($urandom_range(0, 255)) << 3) + 64'(off);
            wd   = {$urandom, $urandom};
            bus  = {$urandom, $urandom};
            aD   = $urandom_range(0, 3);
            dD   = $urandom_range(0, 3);
            ld   = opIsLoad(op);
            wantMis = (off % n) != 0;
            wantRes = ld ? expLoad(op, bus, off) : wd;
            run_mem(op, addr, wd, bus, aD, dD, e, sc, vc, rc, ch, fr, m, mis, to);
            total++;
            if (to || vc !== 1 || mis !== wantMis || m.pc !== e.pc || m.dst !== e.dst) begin
                bad++;
                $display("FAIL rnd%0d_done op=%s to=%b pulses=%0d mis=%b/%b", i, op.name(), to, vc, mis, wantMis);
            end
            if (wantMis) begin
                total++;
                if (rc !== 0 || sc !== 0 || m.ctl.regwrite !== 1'b0) begin
                    bad++; $display("FAIL rnd%0d_mis req=%0d stall=%0d rw=%b want 0 0 0", i, rc, sc, m.ctl.regwrite);
                end
            end else begin
                total++;
                if (sc !== aD + dD + 1 || rc !== aD + 1 || ch !== 1'b0) begin
                    bad++; $display("FAIL rnd%0d_timing stall=%0d req=%0d chg=%b want %0d %0d 0", i, sc, rc, ch, aD + dD + 1, aD + 1);
                end
                total++;
                if (fr.addr !== addr || fr.size !== expSize(op) || fr.strobe !== expStrobe(op, off) ||
                    (!ld && fr.data !== (wd << (8 * off)))) begin
                    bad++; $display("FAIL rnd%0d_req op=%s addr=%h size=%0d strb=%h data=%h want %h %0d %h %h",
                                    i, op.name(), fr.addr, fr.size, fr.strobe, fr.data, addr, expSize(op),
                                    expStrobe(op, off), wd << (8 * off));
                end
                total++;
                if (m.result !== wantRes || m.ctl.regwrite !== ld) begin
                    bad++; $display("FAIL rnd%0d_result op=%s got=%h rw=%b want=%h rw=%b", i, op.name(), m.result, m.ctl.regwrite, wantRes, ld);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1; validE = 1'b0; dataE = '0; dresp = '0;
        test_reset();
        test_sd();
        test_lb();
        test_sh();
        test_lw_delay();
        test_misalign();
        test_passthrough();
        test_reset_wait();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
